muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a shift-add or restoring-divide loop.
- Stalls fetch while busy and presents HI/LO to the writeback mux for MFHI/MFLO.
- Supports direct HI/LO writes for MTHI/MTLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start_EX  input  1  launch operation; sampled only in IDLE.
- op_EX  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a_EX  input  WIDTH  rs operand (multiplicand / dividend).
- b_EX  input  WIDTH  rt operand (multiplier / divisor).
- mthi_EX  input  1  write HI from a_EX.
- mtlo_EX  input  1  write LO from a_EX.
- hi_out  output  WIDTH  HI register.
- lo_out  output  WIDTH  LO register.
- busy  output  1  operation in progress (CALC or SIGN).
- stall_FETCH  output  1  combinational: busy | start_EX.
- done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- dbz  output  1  sticky divide-by-zero flag; cleared by the next accepted start.

Behaviour:
- Reset (rst=0, async): state=IDLE; hi_out=0, lo_out=0, busy=0, done=0, dbz=0; loop counter=0.
- An operation in flight at reset is aborted. No done pulse is produced. HI/LO read 0 after release.
- States:
  - IDLE -> CALC: on start_EX=1.
  - CALC -> SIGN: after WIDTH iterations, counter 0..WIDTH-1.
  - SIGN -> IDLE: unconditional; done=1 in the cycle the SIGN->IDLE edge writes HI/LO.
- Start capture at edge 0:
  - Latch op.
  - Latch magnitudes |a|, |b| for signed ops; raw values for unsigned ops.
  - Latch sign bits: result sign sa^sb, remainder sign sa.
  - Clear dbz. Set dbz=1 if op is DIV/DIVU and b_EX==0.
- Latency:
  - start sampled at edge 0; CALC occupies edges 1..WIDTH; SIGN at edge WIDTH+1.
  - hi_out/lo_out new and done=1 during cycle WIDTH+1, i.e. 33 cycles for WIDTH=32.
- HI/LO are NOT modified during CALC; intermediate values live in internal accumulators.
- Multiply:
  - 2*WIDTH-bit accumulator; one multiplier bit per cycle, LSB first, shift-add.
  - MULT: negate the 2*WIDTH product in SIGN if sa^sb.
  - Result: HI=product[2W-1:W], LO=product[W-1:0].
- Divide:
  - Restoring, one quotient bit per cycle, MSB first, W+1-bit remainder.
  - DIV: negate quotient if sa^sb; negate remainder if sa.
  - Result: LO=quotient, HI=remainder.
  - Magnitude of -2^(W-1) is 2^(W-1) unsigned; no overflow inside the datapath.
  - Overflow case -2^31 / -1: LO=0x80000000, HI=0.
- Divide by zero: result is the natural restoring output — LO=all ones, HI=dividend magnitude, sign fix still applied for DIV. dbz=1.
- start_EX while busy: ignored; the EX instruction is held by stall_FETCH.
- MTHI/MTLO:
  - In IDLE with start_EX=0: HI (and/or LO) <= a_EX at the next edge. Both may assert together.
  - start_EX together with mthi/mtlo: start wins; the writes are dropped.
  - mthi/mtlo while busy: ignored.
- done is never asserted for MTHI/MTLO.
- hi_out/lo_out are registered and stable except at the completion edge or an accepted MT write.

Optional Feature:
- MULDIV_EARLY_OUT_EN
- Defined: multiply leaves CALC as soon as the remaining multiplier bits are all zero, checked after each iteration; the accumulator is aligned (shifted right by the remaining count) in SIGN. Latency = (index of highest set bit of |b| + 1) + 1 cycles. b=0 gives 1 CALC cycle. Divide is unaffected.
- Undefined: fixed WIDTH+1 latency for all operations.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 33, HI=0xFFFFFFFE, LO=0x00000001, stall_FETCH high cycles 0..32.
- MULT a=-3 (0xFFFFFFFD), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=0 -> dbz=1, LO=0xFFFFFFFF, HI=0x00000064. Next MULTU start clears dbz.
- MTHI a=0x12345678 in IDLE -> HI=0x12345678, LO unchanged, no done. mtlo during busy -> LO unchanged. start and mthi together -> operation runs, HI written only by the result.
- Start DIV, drive rst=0 at cycle 10 -> busy=0, HI=LO=0 immediately. No done pulse. New MULTU 2*3 after release -> LO=6.
- With MULDIV_EARLY_OUT_EN: MULTU 5*3 -> done at cycle 3, LO=15. Without the macro: done at cycle 33, LO=15.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiply exits the loop once the remaining multiplier bits are zero.
`timescale 1ns/1ps
`default_nettype none

module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_EX,
    input  logic [1:0]       op_EX,
    input  logic [WIDTH-1:0] a_EX,
    input  logic [WIDTH-1:0] b_EX,
    input  logic             mthi_EX,
    input  logic             mtlo_EX,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             stall_FETCH,
    output logic             done,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     ma_q, ma_d;
    logic [WIDTH-1:0]     mb_q, mb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_trial;
    logic                 div_ok;
    logic                 last_iter;
    logic [2*WIDTH-1:0]   prod_aligned;
    logic [2*WIDTH-1:0]   prod_fixed;

    always_comb begin
        a_mag = (op_EX[0] && a_EX[WIDTH-1]) ? -a_EX : a_EX;
        b_mag = (op_EX[0] && b_EX[WIDTH-1]) ? -b_EX : b_EX;

        // Shift-add: upper half accumulates, product bits shift into the lower half.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mb_q[0] ? ma_q : '0)};

        // Restoring divide: remainder lives in acc upper half, dividend/quotient in mb.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], mb_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, ma_q};
        div_ok    = ~div_trial[WIDTH+1];

        last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
        if (!op_q[1] && (mb_q[WIDTH-1:1] == '0)) begin
            last_iter = 1'b1;
        end
        prod_aligned = acc_q >> (CW'(WIDTH) - cnt_q);
`else
        prod_aligned = acc_q;
`endif
        prod_fixed = neg_res_q ? -prod_aligned : prod_aligned;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start_EX) begin
                    state_d   = S_CALC;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    op_d      = op_EX;
                    ma_d      = op_EX[1] ? b_mag : a_mag;
                    mb_d      = op_EX[1] ? a_mag : b_mag;
                    acc_d     = '0;
                    neg_res_d = op_EX[0] & (a_EX[WIDTH-1] ^ b_EX[WIDTH-1]);
                    neg_rem_d = op_EX[0] & a_EX[WIDTH-1];
                    dbz_d     = op_EX[1] & (b_EX == '0);
                end else begin
                    if (mthi_EX) hi_d = a_EX;
                    if (mtlo_EX) lo_d = a_EX;
                end
            end
            S_CALC: begin
                if (op_q[1]) begin
                    acc_d = {(div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]), {WIDTH{1'b0}}};
                    mb_d  = {mb_q[WIDTH-2:0], div_ok};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    mb_d  = mb_q >> 1;
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = S_SIGN;
                end
            end
            S_SIGN: begin
                if (op_q[1]) begin
                    lo_d = neg_res_q ? -mb_q : mb_q;
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prod_fixed[2*WIDTH-1:WIDTH];
                    lo_d = prod_fixed[WIDTH-1:0];
                end
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ma_q      <= '0;
            mb_q      <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbz         = dbz_q;
    assign stall_FETCH = busy_q | start_EX;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and random MULT/DIV/MT checks against an arithmetic reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_muldiv_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_EX;
    logic [1:0]   op_EX;
    logic [W-1:0] a_EX, b_EX;
    logic         mthi_EX, mtlo_EX;
    logic [W-1:0] hi_out, lo_out;
    logic         busy, stall_FETCH, done, dbz;

    int total = 0;
    int bad   = 0;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_EX    (start_EX),
        .op_EX       (op_EX),
        .a_EX        (a_EX),
        .b_EX        (b_EX),
        .mthi_EX     (mthi_EX),
        .mtlo_EX     (mtlo_EX),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .busy        (busy),
        .stall_FETCH (stall_FETCH),
        .done        (done),
        .dbz         (dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // MIPS HI/LO semantics from plain integer arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        dz = op[1] && (b == 32'd0);
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin
                p  = {32'd0, a} * {32'd0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd1: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32];
                lo = p[31:0];
            end
            2'd2: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                if (b == 32'd0) begin
                    lo = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
                    hi = a;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                end
            end
        endcase
    endfunction

    // Cycles from the start edge to the cycle where done is visible.
    function automatic int latency(input logic [1:0] op, input logic [31:0] b);
        int          n;
        logic [31:0] mag;
        n   = 0;
        mag = (op[0] && b[31]) ? -b : b;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) n = i + 1;
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) return ((n == 0) ? 1 : n) + 1;
`endif
        return W + 1;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic with_mthi, input logic mt_busy);
        logic [31:0] hi0, lo0, ehi, elo;
        logic        edz, hold_ok;
        int          k;
        hi0 = hi_out;
        lo0 = lo_out;
        model(op, a, b, ehi, elo, edz);
        start_EX = 1'b1;
        op_EX    = op;
        a_EX     = a;
        b_EX     = b;
        mthi_EX  = with_mthi;
        #1;
        check({tag, " stall_at_start"}, 64'(stall_FETCH), 64'd1);
        @(posedge clk); #1;
        start_EX = 1'b0;
        mthi_EX  = 1'b0;
        hold_ok  = 1'b1;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            if (!(busy === 1'b1 && stall_FETCH === 1'b1 && hi_out === hi0 && lo_out === lo0))
                hold_ok = 1'b0;
            mtlo_EX = mt_busy && (k == 5);
            if (mt_busy && k == 5) a_EX = 32'hCAFE_F00D;
            @(posedge clk); #1;
            k++;
        end
        mtlo_EX = 1'b0;
        check({tag, " hold_during_busy"}, 64'(hold_ok), 64'd1);
        check({tag, " latency"}, 64'(k), 64'(latency(op, b)));
        check({tag, " hi"}, 64'(hi_out), 64'(ehi));
        check({tag, " lo"}, 64'(lo_out), 64'(elo));
        check({tag, " dbz"}, 64'(dbz), 64'(edz));
        check({tag, " busy_clear"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [31:0] hi_prev, lo_prev, ra, rb;
        logic [1:0]  rop;

        rst = 1'b0; start_EX = 1'b0; op_EX = '0; a_EX = '0; b_EX = '0;
        mthi_EX = 1'b0; mtlo_EX = 1'b0;
        #1;
        check("reset hi", 64'(hi_out), 64'd0);
        check("reset lo", 64'(lo_out), 64'd0);
        check("reset busy/done/dbz", {61'd0, busy, done, dbz}, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("mult_neg",  2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        run_op("div_neg",   2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("div_ovf",   2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("divu_zero", 2'd2, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op("multu_clr", 2'd0, 32'd5, 32'd3, 1'b0, 1'b0);
        run_op("div_zero_neg", 2'd3, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);

        // MTHI in idle, then both MT writes together.
        lo_prev = lo_out;
        mthi_EX = 1'b1; a_EX = 32'h1234_5678;
        @(posedge clk); #1;
        mthi_EX = 1'b0;
        check("mthi hi", 64'(hi_out), 64'h1234_5678);
        check("mthi lo_kept", 64'(lo_out), 64'(lo_prev));
        check("mthi no_done", 64'(done), 64'd0);
        mthi_EX = 1'b1; mtlo_EX = 1'b1; a_EX = 32'hA5A5_0F0F;
        @(posedge clk); #1;
        mthi_EX = 1'b0; mtlo_EX = 1'b0;
        check("mt_both hi", 64'(hi_out), 64'hA5A5_0F0F);
        check("mt_both lo", 64'(lo_out), 64'hA5A5_0F0F);
        check("mt_both no_done", 64'(done), 64'd0);

        run_op("mtlo_busy",  2'd1, 32'h0000_1234, 32'hFFFF_FF00, 1'b0, 1'b1);
        run_op("start_mthi", 2'd2, 32'd1000, 32'd7, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            if (i[0]) rb = rb >> $urandom_range(0, 31);
            run_op("random", rop, ra, rb, 1'b0, 1'b0);
        end

        // Reset in the middle of a divide.
        hi_prev = hi_out;
        start_EX = 1'b1; op_EX = 2'd3; a_EX = 32'hFFFF_1000; b_EX = 32'd9;
        @(posedge clk); #1;
        start_EX = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi_out), 64'd0);
        check("abort lo", 64'(lo_out), 64'd0);
        check("abort prior_hi_nonzero", 64'(hi_prev != 32'd0), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) break;
        end
        check("abort no_done", {62'd0, done, busy}, 64'd0);
        check("abort hilo_after", {hi_out, lo_out}, 64'd0);
        run_op("after_abort", 2'd0, 32'd2, 32'd3, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
